// File: rtl/cfu_cmd_issuer_if.sv
// CFU command/response bus. The issuer is the master: it drives commands and accepts responses.
interface cfu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_issuer.sv
// Queues command requests, issues them one at a time to the CFU, and returns
// each result (or a timeout error word) through an in-order response queue.
module cfu_cmd_issuer #(
    parameter int          CMD_DEPTH = 4,
    parameter int          RSP_DEPTH = 4,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_WORD  = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_function_id,
    input  logic [31:0]      req_inputs_0,
    input  logic [31:0]      req_inputs_1,
    cfu_cmd_issuer_if.master cfu,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [6:0]       res_op,
    output logic             res_err,
    output logic             busy,
    output logic [15:0]      timeout_cnt
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int CPW = CAW + 1;
    localparam int RPW = RAW + 1;
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, PUSH} state_t;

    state_t state, state_nxt;

    logic [9:0]     cq_fid [CMD_DEPTH];
    logic [31:0]    cq_in0 [CMD_DEPTH];
    logic [31:0]    cq_in1 [CMD_DEPTH];
    logic [CAW:0]   cq_wptr, cq_rptr, cq_wptr_nxt, cq_rptr_nxt;
    logic           cmd_push, cmd_pop, cmd_empty, cmd_full_nxt;

    logic [6:0]     rq_op   [RSP_DEPTH];
    logic [31:0]    rq_data [RSP_DEPTH];
    logic           rq_err  [RSP_DEPTH];
    logic [RAW:0]   rq_wptr, rq_rptr;
    logic           res_push, res_pop, rsp_full;

    logic           cmd_valid_q, cmd_valid_nxt;
    logic           rsp_ready_q, rsp_ready_nxt;
    logic [9:0]     fid_q;
    logic [31:0]    in0_q, in1_q, rdata_q;
    logic           rerr_q;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic           cap_rsp, cap_err;

    assign cmd_push     = req_valid && req_ready;
    assign cmd_empty    = (cq_wptr == cq_rptr);
    assign cq_wptr_nxt  = cq_wptr + CPW'(cmd_push);
    assign cq_rptr_nxt  = cq_rptr + CPW'(cmd_pop);
    assign cmd_full_nxt = (cq_wptr_nxt[CAW] != cq_rptr_nxt[CAW]) &&
                          (cq_wptr_nxt[CAW-1:0] == cq_rptr_nxt[CAW-1:0]);

    assign rsp_full  = (rq_wptr[RAW] != rq_rptr[RAW]) && (rq_wptr[RAW-1:0] == rq_rptr[RAW-1:0]);
    assign res_valid = (rq_wptr != rq_rptr);
    assign res_pop   = res_valid && res_ready;
    // Head outputs are masked while empty so an idle queue always reads as zero
    assign res_data  = res_valid ? rq_data[rq_rptr[RAW-1:0]] : 32'd0;
    assign res_op    = res_valid ? rq_op[rq_rptr[RAW-1:0]]   : 7'd0;
    assign res_err   = res_valid ? rq_err[rq_rptr[RAW-1:0]]  : 1'b0;

    assign busy = (state != IDLE) || !cmd_empty || res_valid;

    assign cfu.cmd_valid               = cmd_valid_q;
    assign cfu.rsp_ready               = rsp_ready_q;
    assign cfu.cmd_payload_function_id = fid_q;
    assign cfu.cmd_payload_inputs_0    = in0_q;
    assign cfu.cmd_payload_inputs_1    = in1_q;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cq_fid[cq_wptr[CAW-1:0]] <= req_function_id;
            cq_in0[cq_wptr[CAW-1:0]] <= req_inputs_0;
            cq_in1[cq_wptr[CAW-1:0]] <= req_inputs_1;
        end
        if (res_push) begin
            rq_op[rq_wptr[RAW-1:0]]   <= fid_q[9:3];
            rq_data[rq_wptr[RAW-1:0]] <= rdata_q;
            rq_err[rq_wptr[RAW-1:0]]  <= rerr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_valid_nxt = cmd_valid_q;
        rsp_ready_nxt = rsp_ready_q;
        wait_nxt      = wait_cnt;
        cmd_pop       = 1'b0;
        cap_rsp       = 1'b0;
        cap_err       = 1'b0;
        res_push      = 1'b0;
        case (state)
            IDLE: begin
                // A free response slot is reserved here so PUSH can never overflow
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop       = 1'b1;
                    cmd_valid_nxt = 1'b1;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_valid_q && cfu.cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    rsp_ready_nxt = 1'b1;
                    wait_nxt      = '0;
                    state_nxt     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (cfu.rsp_valid && rsp_ready_q) begin
                    cap_rsp       = 1'b1;
                    rsp_ready_nxt = 1'b0;
                    state_nxt     = PUSH;
                end else if (wait_cnt == WAIT_LAST) begin
                    cap_err       = 1'b1;
                    rsp_ready_nxt = 1'b0;
                    state_nxt     = PUSH;
                end else begin
                    wait_nxt = wait_cnt + WCW'(1);
                end
            end
            PUSH: begin
                res_push  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq_wptr     <= '0;
            cq_rptr     <= '0;
            req_ready   <= 1'b0;
            rq_wptr     <= '0;
            rq_rptr     <= '0;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            fid_q       <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            cq_wptr     <= cq_wptr_nxt;
            cq_rptr     <= cq_rptr_nxt;
            req_ready   <= !cmd_full_nxt;
            rq_wptr     <= rq_wptr + RPW'(res_push);
            rq_rptr     <= rq_rptr + RPW'(res_pop);
            cmd_valid_q <= cmd_valid_nxt;
            rsp_ready_q <= rsp_ready_nxt;
            wait_cnt    <= wait_nxt;
            if (cmd_pop) begin
                fid_q <= cq_fid[cq_rptr[CAW-1:0]];
                in0_q <= cq_in0[cq_rptr[CAW-1:0]];
                in1_q <= cq_in1[cq_rptr[CAW-1:0]];
            end
            if (cap_rsp) begin
                rdata_q <= cfu.rsp_payload_outputs_0;
                rerr_q  <= 1'b0;
            end
            if (cap_err) begin
                rdata_q <= ERR_WORD;
                rerr_q  <= 1'b1;
                if (timeout_cnt != 16'hFFFF) begin
                    timeout_cnt <= timeout_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/cfu_cmd_issuer.md
Name: cfu_cmd_issuer

Overview:
Initiator-side driver for the CFU command/response protocol. It takes queued command requests from a local source (test sequencer, DMA, or a future on-chip controller), issues them one at a time on the cmd_* interface, and collects the rsp_* results. Results are returned through a response queue. A timeout guard aborts any command whose response never arrives. It sits between the control master and the Cfu/TPU block.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in WAIT_RSP before abort (>=2)
ERR_WORD, 32'hDEADBEEF, res_data value returned on timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  command FIFO not full
req_function_id  in  10  function id; op = bits [9:3]
req_inputs_0  in  32  operand 0
req_inputs_1  in  32  operand 1
cmd_valid  out  1  command valid to CFU
cmd_ready  in  1  CFU accepts command
cmd_payload_function_id  out  10  issued function id
cmd_payload_inputs_0  out  32  issued operand 0
cmd_payload_inputs_1  out  32  issued operand 1
rsp_valid  in  1  CFU response valid
rsp_ready  out  1  issuer accepts response
rsp_payload_outputs_0  in  32  CFU response data
res_valid  out  1  response FIFO not empty
res_ready  in  1  consumer pops a response
res_data  out  32  response data (head of FIFO)
res_op  out  7  op of the command that produced res_data
res_err  out  1  1 = timed out, res_data = ERR_WORD
busy  out  1  high when not IDLE or either FIFO non-empty
timeout_cnt  out  16  saturating count of timeouts since reset

Behaviour:
- Reset (rst_n low, async): all FIFOs empty, state IDLE, cmd_valid=0, rsp_ready=0, res_valid=0, busy=0, timeout_cnt=0. req_ready is 1 one cycle after rst_n deasserts. Payload outputs reset to 0.
- Command FIFO: push when req_valid&&req_ready. req_ready = !cmd_full, registered. A simultaneous push and pop when full is not accepted (req_ready=0 while full).
- Only one command outstanding at any time. Commands issue in FIFO order; responses return in the same order.
- FSM:
  - IDLE: if cmd FIFO non-empty and response FIFO has a free slot (count < RSP_DEPTH), pop head into the payload registers, set cmd_valid=1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: hold cmd_valid and payload stable until cmd_valid&&cmd_ready. On that edge set cmd_valid=0 and rsp_ready=1, clear the wait counter, go to WAIT_RSP. No timeout applies in ISSUE.
  - WAIT_RSP: on rsp_valid&&rsp_ready, capture rsp_payload_outputs_0 and set rsp_ready=0, go to PUSH. Otherwise increment the wait counter. When the counter reaches TIMEOUT-1 without a response, set rsp_ready=0, capture ERR_WORD with err=1, increment timeout_cnt (saturate at 16'hFFFF), go to PUSH.
  - PUSH: write {op, data, err} into the response FIFO (a slot is guaranteed by the IDLE check), go to IDLE.
- Minimum latency is 4 cycles from issue to push when cmd_ready and rsp_valid are both already high: IDLE, ISSUE, WAIT_RSP, PUSH. A new command can issue every 4 cycles.
- Response FIFO: pop when res_valid&&res_ready. Outputs show the head entry and stay stable while res_valid&&!res_ready. A push and a pop in the same cycle both take effect.
- A response that arrives after a timeout is not accepted, because rsp_ready=0. Nothing is dropped silently; the CFU must be reset by issuing op 1 through the normal path.
- rsp_valid outside WAIT_RSP is ignored.
- rst_n asserted mid-command aborts immediately. The outstanding command and all queued entries are discarded.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, release -> all outputs 0; req_ready=1 on the next cycle; busy=0.
2. Single command: push op=2 (fid 10'h010), in0=32'd64, CFU model with cmd_ready=1 and rsp after 2 cycles with data 32'h40 -> cmd payload is 10'h010/64; res_data=32'h40, res_op=2, res_err=0.
3. Backpressure: push 6 commands with res_ready=0, RSP_DEPTH=4, CMD_DEPTH=4 -> exactly 4 commands issue; req_ready drops when the cmd FIFO is full; popping one response issues the 5th command.
4. cmd_ready stall: hold cmd_ready=0 for 10 cycles -> cmd_valid stays high with a constant payload; no timeout counting occurs.
5. Timeout: with TIMEOUT=16, the CFU never asserts rsp_valid -> 16 cycles after the accept, res_data=32'hDEADBEEF, res_err=1, timeout_cnt=1; the next queued command then issues normally.
6. Reset mid-WAIT_RSP: assert rst_n=0 -> cmd_valid=0, rsp_ready=0, res_valid=0 asynchronously; FIFOs empty after release.
